// File: rtl/wb_regfile.sv
// Writeback stage: selects load/ALU data and commits it to a 2**ADDR_WIDTH entry register file.
// x0 reads as zero. Two combinational read ports with optional same-cycle bypass. Counts committed writes.
module wb_regfile #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 5,
  parameter int BYPASS_EN   = 1,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   mem_to_reg_in,
  input  logic                   reg_write_en_in,
  input  logic [ADDR_WIDTH-1:0]  rd_reg_addr_in,
  input  logic [DATA_WIDTH-1:0]  data_memory_in,
  input  logic [DATA_WIDTH-1:0]  ALU_result_in,
  input  logic [ADDR_WIDTH-1:0]  rs1_addr,
  input  logic [ADDR_WIDTH-1:0]  rs2_addr,
  output logic [DATA_WIDTH-1:0]  rs1_data,
  output logic [DATA_WIDTH-1:0]  rs2_data,
  output logic [DATA_WIDTH-1:0]  wb_data_out,
  output logic                   wb_commit_out,
  output logic [COUNT_WIDTH-1:0] wb_write_count
);
  localparam int NUM_REGS = 2 ** ADDR_WIDTH;
  localparam int NUM_RD   = 2;

  logic [DATA_WIDTH-1:0]                  regs [NUM_REGS];
  logic [NUM_RD-1:0][ADDR_WIDTH-1:0]      rd_addr;
  logic [NUM_RD-1:0][DATA_WIDTH-1:0]      rd_data;

  assign wb_data_out   = mem_to_reg_in ? data_memory_in : ALU_result_in;
  assign wb_commit_out = reg_write_en_in && (rd_reg_addr_in != '0);

  // Entry 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      wb_write_count <= '0;
    end else if (wb_commit_out) begin
      regs[rd_reg_addr_in] <= wb_data_out;
      wb_write_count       <= wb_write_count + COUNT_WIDTH'(1);
    end
  end

  assign rd_addr  = {rs2_addr, rs1_addr};
  assign rs1_data = rd_data[0];
  assign rs2_data = rd_data[1];

  // Bypass is masked in reset so reads stay zero while storage is held clear.
  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic hit;
    assign hit = (BYPASS_EN != 0) && rst_n && wb_commit_out &&
                 (rd_addr[p] == rd_reg_addr_in);
    assign rd_data[p] = (rd_addr[p] == '0) ? '0 :
                        hit                ? wb_data_out :
                                             regs[rd_addr[p]];
  end
endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
Writeback-side consumer of the MEM/WB pipeline register outputs. Selects the writeback value (data memory load or ALU result) and commits it to a 32-entry integer register file with x0 hardwired to zero. Provides two combinational read ports for the decode stage, with optional same-cycle write-to-read bypass, plus a counter of committed writes for debug and performance.

Parameters:
DATA_WIDTH, 32, register and datapath width in bits
ADDR_WIDTH, 5, register index width; 2**ADDR_WIDTH entries
BYPASS_EN, 1, 1 = a read of the register being written this cycle returns the new value; 0 = the read returns the stored (old) value
COUNT_WIDTH, 32, width of the committed-write counter

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
mem_to_reg_in  input  1  1 = write back data_memory_in; 0 = write back ALU_result_in
reg_write_en_in  input  1  writeback write enable
rd_reg_addr_in  input  ADDR_WIDTH  destination register index
data_memory_in  input  DATA_WIDTH  load data from the MEM/WB register
ALU_result_in  input  DATA_WIDTH  ALU result from the MEM/WB register
rs1_addr  input  ADDR_WIDTH  read port 1 index
rs2_addr  input  ADDR_WIDTH  read port 2 index
rs1_data  output  DATA_WIDTH  read port 1 data, combinational
rs2_data  output  DATA_WIDTH  read port 2 data, combinational
wb_data_out  output  DATA_WIDTH  selected writeback value, combinational
wb_commit_out  output  1  1 when an effective write occurs this cycle (enable=1 and rd!=0), combinational
wb_write_count  output  COUNT_WIDTH  number of committed writes, registered

Behaviour:
- Clocking and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset (rst_n=0), applied immediately and independent of clk:
  - all register entries clear to 0
  - wb_write_count clears to 0
  - rs1_data and rs2_data read 0
  - wb_data_out and wb_commit_out follow their inputs combinationally
- While rst_n=0, no write or count update takes place. The first clock edge after rst_n deasserts behaves normally.
- Writeback mux: wb_data_out = mem_to_reg_in ? data_memory_in : ALU_result_in. The mux is purely combinational.
- Write:
  - On posedge clk, if reg_write_en_in=1 and rd_reg_addr_in!=0, entry[rd] <= wb_data_out.
  - Latency: the value is visible in storage one edge later.
- x0:
  - Writes to index 0 are discarded: no storage change and no count increment.
  - A read of index 0 always returns 0, including when the bypass would otherwise apply.
- Read: rsN_data = (rsN_addr==0) ? 0 : entry[rsN_addr]. Reads are combinational with no clock latency.
- Bypass (BYPASS_EN=1):
  - Applies when wb_commit_out=1 and rsN_addr==rd_reg_addr_in.
  - rsN_data = wb_data_out in the same cycle.
  - Both ports bypass independently. Both may bypass simultaneously when rs1_addr==rs2_addr==rd.
- BYPASS_EN=0: a read of the register being written returns the old value until the next edge.
- Counter:
  - On posedge clk, wb_write_count increments by 1 when wb_commit_out=1.
  - It wraps modulo 2**COUNT_WIDTH; it does not saturate.
- The input fields mem_to_reg_in and data_memory_in are ignored unless a write commits. There are no X-propagation requirements on unused data.
- Reset asserted in the middle of a cycle with a pending write: the write is lost, storage clears, and the count is 0.

Test Plan:
- Reset: drive rst_n=0 asynchronously between edges -> rs1_data=rs2_data=0 for all indices, wb_write_count=0 before the next clk edge.
- ALU write then read: en=1, mem_to_reg=0, rd=5, ALU=0xDEADBEEF, one edge, then rs1_addr=5 -> rs1_data=0xDEADBEEF, wb_write_count=1.
- Load write through the mux: en=1, mem_to_reg=1, rd=7, mem=0x12345678, ALU=0xFFFFFFFF -> after the edge, entry 7 reads 0x12345678.
- x0 protection: en=1, rd=0, ALU=0xAAAAAAAA -> wb_commit_out=0 and reads of index 0 return 0. Count unchanged.
- Bypass (BYPASS_EN=1): entry 3 = 0x1, then same cycle en=1, rd=3, ALU=0x2, rs1=rs2=3 -> both ports return 0x2 before the edge. With BYPASS_EN=0 -> both return 0x1 before the edge and 0x2 after.
- Counter wrap (COUNT_WIDTH=4): 16 committed writes -> wb_write_count returns to 0. Writes with en=0 interleaved -> no increment.
